// File: rtl/aes_round_ctrl_if.sv
// Interface bundling the host handshake, round-datapath and ciphertext byte
// stream signals of aes_round_ctrl. The controller takes the slave view; the
// surrounding host/datapath/consumer logic takes the master view.
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key;

    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [7:0]   rnd_rcon;
    logic         rnd_last;
    logic [127:0] rnd_state_nxt;
    logic [127:0] rnd_key_nxt;

    logic         out_valid;
    logic         out_ready;
    logic [7:0]   data_out;
    logic         out_last;

    modport slave (
        input  in_valid, data_in, key, rnd_state_nxt, rnd_key_nxt, out_ready,
        output in_ready, rnd_state, rnd_key, rnd_rcon, rnd_last,
               out_valid, data_out, out_last
    );

    modport master (
        output in_valid, data_in, key, rnd_state_nxt, rnd_key_nxt, out_ready,
        input  in_ready, rnd_state, rnd_key, rnd_rcon, rnd_last,
               out_valid, data_out, out_last
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES-128 encryption datapath.
// Accepts plaintext/key, applies the initial AddRoundKey, steps an external
// combinational round datapath ten times (supplying round state, round key,
// rcon and last-round flag), then serializes the ciphertext as 16 bytes.
// Optional feature macro: AES_CTRL_ABORT_EN adds a synchronous 'abort' input
// that returns the controller to IDLE from ROUND or DRAIN.
module aes_round_ctrl #(
    parameter int NR        = 10,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    aes_round_ctrl_if.slave bus
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic            abort
`endif
);

    // Only AES-128 is supported; any other round count is rejected.
    if (NR != 10) begin : g_nr_check
        $error("aes_round_ctrl: NR must be 10 (AES-128 only)");
    end

    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DRAIN
    } state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic [3:0]   r_cnt;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_out_last;
    logic [7:0]   r_data_out;
    logic         r_rnd_last;

    logic         w_accept;
    logic         w_abort;
    logic         w_final_round;
    logic [7:0]   w_rcon_nxt;

    // GF(2^8) multiply-by-x used to advance rcon.
    function automatic logic [7:0] f_xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Select ciphertext byte 'idx' in transmission order.
    function automatic logic [7:0] f_byte(input logic [127:0] s, input logic [3:0] idx);
        logic [7:0] b;
        b = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (idx == i[3:0]) begin
                b = MSB_FIRST ? s[8*(15-i) +: 8] : s[8*i +: 8];
            end
        end
        return b;
    endfunction

`ifdef AES_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept      = bus.in_valid && r_in_ready;
    assign w_final_round = (r_round == LP_NR);
    assign w_rcon_nxt    = f_xtime(r_rcon);

    assign bus.in_ready  = r_in_ready;
    assign bus.rnd_state = r_state;
    assign bus.rnd_key   = r_key;
    assign bus.rnd_rcon  = r_rcon;
    assign bus.rnd_last  = r_rnd_last;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;
    assign bus.out_last  = r_out_last;

    // Main controller FSM; all externally visible outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_rcon      <= 8'h01;
            r_round     <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_data_out  <= '0;
            r_rnd_last  <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= bus.data_in ^ bus.key;
                        r_key      <= bus.key;
                        r_round    <= 4'd1;
                        r_rcon     <= 8'h01;
                        r_rnd_last <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_fsm      <= ROUND;
                    end
                end

                ROUND: begin
                    if (w_abort) begin
                        r_fsm       <= IDLE;
                        r_round     <= '0;
                        r_cnt       <= '0;
                        r_rnd_last  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_data_out  <= '0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_state <= bus.rnd_state_nxt;
                        r_key   <= bus.rnd_key_nxt;
                        r_rcon  <= w_rcon_nxt;
                        if (w_final_round) begin
                            // The datapath result registered on this edge is the ciphertext;
                            // preload its first byte so data_out is valid on entry to DRAIN.
                            r_fsm       <= DRAIN;
                            r_round     <= '0;
                            r_cnt       <= '0;
                            r_rnd_last  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_data_out  <= f_byte(bus.rnd_state_nxt, 4'd0);
                        end else begin
                            r_round    <= r_round + 4'd1;
                            r_rnd_last <= (r_round == (LP_NR - 4'd1));
                        end
                    end
                end

                DRAIN: begin
                    if (w_abort) begin
                        r_fsm       <= IDLE;
                        r_round     <= '0;
                        r_cnt       <= '0;
                        r_rnd_last  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_data_out  <= '0;
                        r_in_ready  <= 1'b1;
                    end else if (bus.out_ready) begin
                        if (r_cnt == 4'd15) begin
                            r_fsm       <= IDLE;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_data_out  <= '0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_cnt      <= r_cnt + 4'd1;
                            r_data_out <= f_byte(r_state, r_cnt + 4'd1);
                            r_out_last <= (r_cnt == 4'd14);
                        end
                    end
                end

                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: a behavioural AES round datapath
// drives rnd_*_nxt, and a whole-block AES-128 reference model supplies the
// expected ciphertext for directed and random blocks.
module tb_aes_round_ctrl;

    logic clk;
    logic rst;
`ifdef AES_CTRL_ABORT_EN
    logic abort;
`endif

    int total;
    int bad;

    logic [7:0] sbox [256];

    localparam logic [7:0] RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_round_ctrl_if u_if ();

    aes_round_ctrl #(.NR(10), .MSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (u_if)
`ifdef AES_CTRL_ABORT_EN
        ,
        .abort (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES behavioural model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1B;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            inv = 8'h01;
            if (x == 8'h00) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // byte (row r, column c) of the 128-bit state, FIPS-197 column-major order
    function automatic logic [7:0] getb(input logic [127:0] s, input int r, input int c);
        return s[127 - 8*(4*c + r) -: 8];
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [7:0] m [4][4];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = sbox[getb(s, r, (c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = m[0][c]; a1 = m[1][c]; a2 = m[2][c]; a3 = m[3][c];
            if (!last) begin
                m[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                m[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                m[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                m[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(4*c + r) -: 8] = m[r][c];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k_in);
        logic [127:0] s, k;
        k = k_in;
        s = pt ^ k;
        for (int r = 0; r < 10; r++) begin
            k = key_exp(k, RCON_TAB[r]);
            s = aes_round(s, k, r == 9);
        end
        return s;
    endfunction

    // Combinational round datapath attached to the controller, evaluated mid-cycle.
    always @(negedge clk) begin
        u_if.rnd_key_nxt   = key_exp(u_if.rnd_key, u_if.rnd_rcon);
        u_if.rnd_state_nxt = aes_round(u_if.rnd_state, u_if.rnd_key_nxt, u_if.rnd_last);
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  128'(u_if.in_ready),  128'(1'b1));
        chk({tag, "_out_valid"}, 128'(u_if.out_valid), 128'(1'b0));
        chk({tag, "_out_last"},  128'(u_if.out_last),  128'(1'b0));
        chk({tag, "_data_out"},  128'(u_if.data_out),  128'(8'h00));
        chk({tag, "_rnd_last"},  128'(u_if.rnd_last),  128'(1'b0));
        chk({tag, "_rnd_rcon"},  128'(u_if.rnd_rcon),  128'(8'h01));
        chk({tag, "_rnd_state"}, u_if.rnd_state, 128'h0);
        chk({tag, "_rnd_key"},   u_if.rnd_key,   128'h0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Present one block, follow it through ten rounds and collect its 16 bytes.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                             input int stall_at, input int stall_n, input bit chk_seq,
                             input bit hold_next, input logic [127:0] npt, input logic [127:0] nk,
                             input int abort_at);
        logic [127:0] got;
        int waited, n, stalls, budget;
        u_if.in_valid = 1'b1;
        u_if.data_in  = pt;
        u_if.key      = k;
        waited = 0;
        while (u_if.in_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk("idle_in_ready", 128'(u_if.in_ready), 128'(1'b1));
        @(negedge clk);
        if (hold_next) begin
            u_if.data_in = npt;
            u_if.key     = nk;
        end else begin
            u_if.in_valid = 1'b0;
            u_if.data_in  = rnd128();
            u_if.key      = rnd128();
        end
        for (int r = 1; r <= 10; r++) begin
            chk("round_in_ready",  128'(u_if.in_ready),  128'(1'b0));
            chk("round_out_valid", 128'(u_if.out_valid), 128'(1'b0));
            if (r == 1) chk("round1_state", u_if.rnd_state, pt ^ k);
            if (chk_seq) begin
                chk("round_rcon", 128'(u_if.rnd_rcon), 128'(RCON_TAB[r-1]));
                chk("round_last", 128'(u_if.rnd_last), 128'(r == 10));
            end
            @(negedge clk);
        end
        got = '0; n = 0; stalls = 0; budget = 0;
        while (n < 16 && budget < 80) begin
            budget++;
            if (n == stall_at && stalls < stall_n) begin
                u_if.out_ready = 1'b0;
                chk("stall_valid", 128'(u_if.out_valid), 128'(1'b1));
                chk("stall_data",  128'(u_if.data_out),  128'(ct[8*(15-n) +: 8]));
                chk("stall_last",  128'(u_if.out_last),  128'(n == 15));
                stalls++;
                @(negedge clk);
            end else begin
`ifdef AES_CTRL_ABORT_EN
                if (n == abort_at) begin
                    abort = 1'b1;
                    u_if.out_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_out_valid", 128'(u_if.out_valid), 128'(1'b0));
                    chk("abort_in_ready",  128'(u_if.in_ready),  128'(1'b1));
                    chk("abort_out_last",  128'(u_if.out_last),  128'(1'b0));
                    return;
                end
`endif
                u_if.out_ready = 1'b1;
                chk("byte_valid", 128'(u_if.out_valid), 128'(1'b1));
                chk("byte_data",  128'(u_if.data_out),  128'(ct[8*(15-n) +: 8]));
                chk("byte_last",  128'(u_if.out_last),  128'(n == 15));
                got[8*(15-n) +: 8] = u_if.data_out;
                @(negedge clk);
                n++;
            end
        end
        chk("byte_count", 128'(n), 128'(16));
        chk("ct_stream", got, ct);
        chk("done_in_ready",  128'(u_if.in_ready),  128'(1'b1));
        chk("done_out_valid", 128'(u_if.out_valid), 128'(1'b0));
        if (abort_at >= 0) chk("abort_unused", 128'(abort_at), 128'(-1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] fpt, fkey, fct, pa, ka, pb, kb, p, k;
        total = 0;
        bad   = 0;
        fpt  = 128'h3243f6a8885a308d313198a2e0370734;
        fkey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fct  = 128'h3925841d02dc09fbdc118597196a0b32;
        build_sbox();
        rst = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.data_in   = '0;
        u_if.key       = '0;
        u_if.out_ready = 1'b1;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 vector with rcon / rnd_last sequence
        run_block(fpt, fkey, fct, -1, 0, 1'b1, 1'b0, '0, '0, -1);

        // Backpressure on the fifth byte for three cycles
        run_block(fpt, fkey, fct, 4, 3, 1'b0, 1'b0, '0, '0, -1);

        // Back-to-back: second block held on the inputs during the first
        pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
        run_block(pa, ka, aes_ref(pa, ka), -1, 0, 1'b0, 1'b1, pb, kb, -1);
        run_block(pb, kb, aes_ref(pb, kb), -1, 0, 1'b0, 1'b0, '0, '0, -1);

        // Reset asserted during round 4
        p = rnd128(); k = rnd128();
        u_if.in_valid = 1'b1; u_if.data_in = p; u_if.key = k;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_round4_rcon", 128'(u_if.rnd_rcon), 128'(8'h08));
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 128'(u_if.out_valid), 128'(1'b0));
        p = rnd128(); k = rnd128();
        run_block(p, k, aes_ref(p, k), -1, 0, 1'b1, 1'b0, '0, '0, -1);

        // Random blocks with a random stall position
        for (int b = 0; b < 3; b++) begin
            p = rnd128(); k = rnd128();
            run_block(p, k, aes_ref(p, k), int'($urandom_range(0, 15)),
                      int'($urandom_range(1, 4)), 1'b0, 1'b0, '0, '0, -1);
        end

`ifdef AES_CTRL_ABORT_EN
        // Abort during DRAIN at byte 8, then a fresh block from its own byte 0
        p = rnd128(); k = rnd128();
        run_block(p, k, aes_ref(p, k), -1, 0, 1'b0, 1'b0, '0, '0, 8);
        p = rnd128(); k = rnd128();
        run_block(p, k, aes_ref(p, k), -1, 0, 1'b1, 1'b0, '0, '0, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
